// File: rtl/hdlc_rx_line_checker.sv
// hdlc_rx_line_checker: passive checker for an HDLC receive path.
// Decodes the serial Rx line (flags, stuffed zeros, aborts, idle) and tracks
// the frame state. It cross-checks the receiver's flag pulse and abort status,
// keeps saturating event counters and sticky error flags.
//
// Optional feature: define HDLC_CHK_LENGTH_EN to enable the MIN/MAX frame
// length check (ErrFlags[3]). Without it, ErrFlags[3] stays 0.
//
// Ports:
//   Clk            clock, rising edge
//   Rst            synchronous active-low reset
//   Rx             serial line bit, one per cycle
//   Rx_FlagDetect  receiver flag pulse under check
//   Rx_AbortSignal receiver abort status under check
//   ClrStat        synchronous clear of counters and sticky flags
//   InFrame        checker is inside a frame
//   Idle           ones run >= IDLE_ONES
//   FlagCnt        flags seen
//   FrameCnt       non-empty frames closed
//   AbortCnt       aborts seen inside a frame
//   ErrCnt         cycles carrying at least one error event
//   ErrFlags       sticky errors: [0] flag latency, [1] abort missing,
//                  [2] octet alignment, [3] length
module hdlc_rx_line_checker #(
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned ABORT_WIN = 4,
  parameter int unsigned IDLE_ONES = 8,
  parameter int unsigned MIN_BYTES = 4,
  parameter int unsigned MAX_BYTES = 128,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Rx,
  input  logic             Rx_FlagDetect,
  input  logic             Rx_AbortSignal,
  input  logic             ClrStat,
  output logic             InFrame,
  output logic             Idle,
  output logic [CNT_W-1:0] FlagCnt,
  output logic [CNT_W-1:0] FrameCnt,
  output logic [CNT_W-1:0] AbortCnt,
  output logic [CNT_W-1:0] ErrCnt,
  output logic [3:0]       ErrFlags
);

  localparam int unsigned ONES_W   = $clog2(IDLE_ONES + 1);
  localparam int unsigned WIN_W    = $clog2(ABORT_WIN + 1);
  localparam int unsigned BITS_MAX = 8 * (MAX_BYTES + 1) + 7;
  localparam int unsigned BITS_W   = $clog2(BITS_MAX + 1);

  typedef enum logic {HUNT = 1'b0, FRAME = 1'b1} state_e;

  state_e              state_q;
  logic [6:0]          sr_q;        // only the 7 bits preceding Rx are needed
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [BITS_W-1:0]   bits_q, bits_d;
  logic [FLAG_LAT-1:0] pipe_q;
  logic [WIN_W-1:0]    win_q, win_d;
  logic                expired_q, expired_d;

  logic              in_frame, flag_match, abort_match, abort_evt;
  logic              stuffed, close_frame;
  logic [BITS_W-1:0] dlen;
  logic [3:0]        err_ev;

  // Saturating counter update; a clear in the same cycle as an event yields 1.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cnt;
    if (inc && (base != '1)) return base + CNT_W'(1);
    return base;
  endfunction

  // Line decode, destuffing, window and error events.
  always_comb begin
    in_frame    = (state_q == FRAME);
    flag_match  = ({sr_q, Rx} == 8'h7E);
    abort_match = Rx && (ones_q == ONES_W'(6));
    abort_evt   = in_frame && abort_match;
    stuffed     = in_frame && !Rx && (ones_q == ONES_W'(5));
    close_frame = in_frame && flag_match && (bits_q > BITS_W'(7));
    // bits_q includes the closing flag's leading 0 and six ones.
    dlen        = bits_q - BITS_W'(7);

    ones_d = '0;
    if (Rx) ones_d = (ones_q == ONES_W'(IDLE_ONES)) ? ones_q : ones_q + ONES_W'(1);

    bits_d = bits_q;
    if (!in_frame || flag_match) bits_d = '0;
    else if (!stuffed && (bits_q != BITS_W'(BITS_MAX))) bits_d = bits_q + BITS_W'(1);

    // Miss is reported one edge after the window runs out.
    win_d     = win_q;
    expired_d = 1'b0;
    if (abort_evt) begin
      win_d = WIN_W'(ABORT_WIN);
    end else if (win_q != '0) begin
      if (Rx_AbortSignal) begin
        win_d = '0;
      end else begin
        win_d     = win_q - WIN_W'(1);
        expired_d = (win_q == WIN_W'(1));
      end
    end

    err_ev[0] = (pipe_q[FLAG_LAT-1] != Rx_FlagDetect);
    err_ev[1] = expired_q;
    err_ev[2] = close_frame && (dlen[2:0] != 3'd0);
`ifdef HDLC_CHK_LENGTH_EN
    err_ev[3] = close_frame && ((32'(dlen >> 3) < MIN_BYTES) ||
                                (32'(dlen >> 3) > MAX_BYTES));
`else
    err_ev[3] = 1'b0;
`endif
  end

`ifndef HDLC_CHK_LENGTH_EN
  logic len_unused;
  assign len_unused = ^{dlen[BITS_W-1:3], (MIN_BYTES > MAX_BYTES)};
`endif

  // State, decode registers and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      ones_q    <= '0;
      bits_q    <= '0;
      pipe_q    <= '0;
      win_q     <= '0;
      expired_q <= 1'b0;
      InFrame   <= 1'b0;
      Idle      <= 1'b0;
      FlagCnt   <= '0;
      FrameCnt  <= '0;
      AbortCnt  <= '0;
      ErrCnt    <= '0;
      ErrFlags  <= 4'b0000;
    end else begin
      sr_q      <= {sr_q[5:0], Rx};
      ones_q    <= ones_d;
      bits_q    <= bits_d;
      pipe_q    <= (pipe_q << 1) | FLAG_LAT'(flag_match);
      win_q     <= win_d;
      expired_q <= expired_d;
      Idle      <= (ones_d >= ONES_W'(IDLE_ONES));

      if (state_q == HUNT) begin
        if (flag_match) begin
          state_q <= FRAME;
          InFrame <= 1'b1;
        end
      end else begin
        if (abort_match) begin
          state_q <= HUNT;
          InFrame <= 1'b0;
        end
      end

      FlagCnt  <= cnt_next(FlagCnt, flag_match, ClrStat);
      FrameCnt <= cnt_next(FrameCnt, close_frame, ClrStat);
      AbortCnt <= cnt_next(AbortCnt, abort_evt, ClrStat);
      ErrCnt   <= cnt_next(ErrCnt, |err_ev, ClrStat);
      ErrFlags <= (ClrStat ? 4'b0000 : ErrFlags) | err_ev;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_line_checker.sv
// Testbench for hdlc_rx_line_checker: builds HDLC line streams at frame/byte
// level (stuffing applied by the bench), derives expected counters from the
// frame contents, and compares against the DUT.
module tb_hdlc_rx_line_checker;

  localparam int FLAG_LAT  = 2;
  localparam int ABORT_WIN = 4;
  localparam int IDLE_ONES = 8;
  localparam int MIN_BYTES = 4;
  localparam int MAX_BYTES = 128;
  localparam int CNT_W     = 16;
  localparam int STAT_W    = 4 * CNT_W + 4;
`ifdef HDLC_CHK_LENGTH_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             Rx = 1'b1;
  logic             Rx_FlagDetect = 1'b0;
  logic             Rx_AbortSignal = 1'b0;
  logic             ClrStat = 1'b0;
  logic             InFrame, Idle;
  logic [CNT_W-1:0] FlagCnt, FrameCnt, AbortCnt, ErrCnt;
  logic [3:0]       ErrFlags;

  int checks = 0;
  int errors = 0;

  // Stream model: raw line bits, flag closing indices and expected tallies.
  bit       line_q[$];
  int       fend_q[$];
  int       run, cur_n;
  bit       open;
  int       e_flag, e_frame, e_errcnt;
  logic [3:0] e_flags;

  hdlc_rx_line_checker #(
    .FLAG_LAT(FLAG_LAT), .ABORT_WIN(ABORT_WIN), .IDLE_ONES(IDLE_ONES),
    .MIN_BYTES(MIN_BYTES), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortSignal(Rx_AbortSignal), .ClrStat(ClrStat),
    .InFrame(InFrame), .Idle(Idle), .FlagCnt(FlagCnt), .FrameCnt(FrameCnt),
    .AbortCnt(AbortCnt), .ErrCnt(ErrCnt), .ErrFlags(ErrFlags)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic new_line();
    line_q.delete();
    fend_q.delete();
    run = 0; cur_n = 0; open = 1'b0;
    e_flag = 0; e_frame = 0; e_errcnt = 0; e_flags = 4'b0000;
  endtask

  task automatic add_ones(input int n);
    repeat (n) line_q.push_back(1'b1);
  endtask

  // One destuffed data bit; a 0 is inserted after every five consecutive ones.
  task automatic add_bit(input bit b);
    line_q.push_back(b);
    cur_n++;
    if (b) begin
      run++;
      if (run == 5) begin
        line_q.push_back(1'b0);
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) add_bit(v[i]);
  endtask

  // Flag; 'shared' reuses the previous flag's closing 0 as its leading 0.
  task automatic add_flag(input bit shared);
    int d;
    logic [3:0] ev;
    if (open && cur_n > 0) begin
      d  = (cur_n > 8 * (MAX_BYTES + 1)) ? 8 * (MAX_BYTES + 1) : cur_n;
      ev = 4'b0000;
      e_frame++;
      ev[2] = (d % 8) != 0;
      ev[3] = LEN_EN && (((d / 8) < MIN_BYTES) || ((d / 8) > MAX_BYTES));
      if (ev != 4'b0000) e_errcnt++;
      e_flags |= ev;
    end
    if (!shared) line_q.push_back(1'b0);
    repeat (6) line_q.push_back(1'b1);
    line_q.push_back(1'b0);
    fend_q.push_back(line_q.size() - 1);
    e_flag++;
    open = 1'b1; cur_n = 0; run = 0;
  endtask

  function automatic bit det_at(input int i, input int delay);
    foreach (fend_q[j]) if (fend_q[j] + delay == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit rx, input bit det, input bit ab, input bit clr);
    Rx = rx; Rx_FlagDetect = det; Rx_AbortSignal = ab; ClrStat = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic play(input int delay, input int clr_idx);
    for (int i = 0; i < line_q.size(); i++)
      step(line_q[i], det_at(i, delay), 1'b0, i == clr_idx);
    Rx = 1'b1; Rx_FlagDetect = 1'b0; Rx_AbortSignal = 1'b0; ClrStat = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b0; Rx = 1'b1; Rx_FlagDetect = 1'b0; Rx_AbortSignal = 1'b0; ClrStat = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [STAT_W-1:0] got;
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    checks++;
    if (got !== '0 || InFrame !== 1'b0 || Idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got stats=%h InFrame=%b Idle=%b, expected all 0", got, InFrame, Idle);
    end
    Rst = 1'b1;
    new_line(); add_ones(2); add_flag(1'b0);
    for (int i = 0; i < 20; i++) add_bit(1'($urandom));
    play(FLAG_LAT, -1);
    checks++;
    if (InFrame !== 1'b1) begin
      errors++;
      $display("FAIL midframe_inframe: got %b expected 1", InFrame);
    end
    Rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    new_line(); add_ones(5);
    play(FLAG_LAT, -1);
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    checks++;
    if (got !== '0 || InFrame !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got stats=%h InFrame=%b, expected all 0", got, InFrame);
    end
  endtask

  task automatic test_idle();
    logic [STAT_W-1:0] got;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (Idle !== (k >= IDLE_ONES) || InFrame !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got Idle=%b InFrame=%b expected Idle=%b InFrame=0",
                 k, Idle, InFrame, (k >= IDLE_ONES));
      end
    end
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL idle_counters: got %h expected 0", got);
    end
  endtask

  task automatic build_good_frame();
    new_line(); add_ones(3); add_flag(1'b0);
    add_byte(8'hFF); add_byte(8'h7E); add_byte(8'h01); add_byte(8'h02);
    add_flag(1'b0); add_ones(5);
  endtask

  task automatic test_good_frame();
    logic [STAT_W-1:0] got, exp;
    do_reset();
    build_good_frame();
    play(FLAG_LAT, -1);
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    exp = {CNT_W'(e_flag), CNT_W'(e_frame), CNT_W'(0), CNT_W'(e_errcnt), e_flags};
    checks++;
    if (got !== exp || FlagCnt !== CNT_W'(2) || FrameCnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL good_frame: got %h expected %h", got, exp);
    end
    checks++;
    if (InFrame !== 1'b1) begin
      errors++;
      $display("FAIL good_frame_inframe: got %b expected 1", InFrame);
    end
  endtask

  task automatic test_flag_latency();
    logic [STAT_W-1:0] got, exp;
    do_reset();
    build_good_frame();
    play(FLAG_LAT + 1, -1);
    // Each flag yields one missing and one spurious pulse, on separate cycles.
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    exp = {CNT_W'(e_flag), CNT_W'(e_frame), CNT_W'(0), CNT_W'(e_errcnt + 2 * e_flag),
           e_flags | 4'b0001};
    checks++;
    if (got !== exp || ErrCnt !== CNT_W'(4)) begin
      errors++;
      $display("FAIL flag_latency: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_abort(input bit ack);
    logic [STAT_W-1:0] got, exp;
    int am;
    do_reset();
    new_line(); add_ones(2); add_flag(1'b0);
    add_byte(8'($urandom)); add_byte(8'($urandom));
    line_q.push_back(1'b0);
    add_ones(7);
    am = line_q.size() - 1;
    add_ones(8);
    for (int i = 0; i < line_q.size(); i++) begin
      step(line_q[i], det_at(i, FLAG_LAT), ack && (i == am + 3), 1'b0);
      if (i == am) begin
        checks++;
        if (InFrame !== 1'b0 || AbortCnt !== CNT_W'(1)) begin
          errors++;
          $display("FAIL abort_match: got InFrame=%b AbortCnt=%0d expected 0 and 1", InFrame, AbortCnt);
        end
      end
      if (i == am + ABORT_WIN) begin
        checks++;
        if (ErrFlags[1] !== 1'b0) begin
          errors++;
          $display("FAIL abort_early_ack%0d: got ErrFlags[1]=%b expected 0", ack, ErrFlags[1]);
        end
      end
      if (i == am + ABORT_WIN + 1) begin
        checks++;
        if (ErrFlags[1] !== !ack) begin
          errors++;
          $display("FAIL abort_miss_ack%0d: got ErrFlags[1]=%b expected %b", ack, ErrFlags[1], !ack);
        end
      end
    end
    Rx = 1'b1; Rx_AbortSignal = 1'b0;
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    exp = {CNT_W'(1), CNT_W'(0), CNT_W'(1), CNT_W'(ack ? 0 : 1), ack ? 4'b0000 : 4'b0010};
    checks++;
    if (got !== exp || Idle !== 1'b1) begin
      errors++;
      $display("FAIL abort_final_ack%0d: got %h Idle=%b expected %h Idle=1", ack, got, Idle, exp);
    end
  endtask

  task automatic test_alignment();
    logic [STAT_W-1:0] got, exp;
    do_reset();
    new_line(); add_ones(2); add_flag(1'b0);
    for (int i = 0; i < 37; i++) add_bit(1'($urandom));
    add_flag(1'b0); add_ones(5);
    play(FLAG_LAT, -1);
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    exp = {CNT_W'(e_flag), CNT_W'(e_frame), CNT_W'(0), CNT_W'(e_errcnt), e_flags};
    checks++;
    if (got !== exp || ErrFlags !== 4'b0100 || FrameCnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL alignment: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_length_clear();
    logic [STAT_W-1:0] got, exp;
    do_reset();
    new_line(); add_ones(2); add_flag(1'b0);
    add_byte(8'($urandom)); add_byte(8'($urandom));
    add_flag(1'b0); add_ones(5);
    play(FLAG_LAT, -1);
    checks++;
    if (ErrFlags !== {LEN_EN, 3'b000} || FrameCnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL length_short: got ErrFlags=%b FrameCnt=%0d expected %b and 1",
               ErrFlags, FrameCnt, {LEN_EN, 3'b000});
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    checks++;
    if (got !== '0 || InFrame !== 1'b1) begin
      errors++;
      $display("FAIL clear: got stats=%h InFrame=%b expected 0 and 1", got, InFrame);
    end
    // Clear on the same edge as a misaligned frame close: the event survives.
    do_reset();
    new_line(); add_ones(2); add_flag(1'b0);
    for (int i = 0; i < 37; i++) add_bit(1'($urandom));
    add_flag(1'b0); add_ones(5);
    play(FLAG_LAT, fend_q[1]);
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    exp = {CNT_W'(1), CNT_W'(1), CNT_W'(0), CNT_W'(1), 4'b0100};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL clear_with_event: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_long_frame();
    logic [STAT_W-1:0] got, exp;
    do_reset();
    new_line(); add_ones(2); add_flag(1'b0);
    for (int i = 0; i < 8 * MAX_BYTES; i++) add_bit(1'($urandom));
    add_flag(1'b0);
    for (int i = 0; i < 8 * (MAX_BYTES + 2) + 3; i++) add_bit(1'($urandom));
    add_flag(1'b0); add_ones(5);
    play(FLAG_LAT, -1);
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    exp = {CNT_W'(e_flag), CNT_W'(e_frame), CNT_W'(0), CNT_W'(e_errcnt), e_flags};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL long_frame: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [STAT_W-1:0] got, exp;
    int nbits;
    do_reset();
    new_line(); add_ones(3); add_flag(1'b0);
    for (int f = 0; f < 40; f++) begin
      nbits = 8 * int'($urandom_range(8, 1));
      if ($urandom_range(3, 0) == 0) nbits += int'($urandom_range(7, 1));
      for (int i = 0; i < nbits; i++) add_bit(1'($urandom));
      add_flag(1'b0);
      case ($urandom_range(4, 0))
        0: add_flag(1'b0);
        1: add_flag(1'b1);
        default: ;
      endcase
    end
    add_ones(5);
    play(FLAG_LAT, -1);
    got = {FlagCnt, FrameCnt, AbortCnt, ErrCnt, ErrFlags};
    exp = {CNT_W'(e_flag), CNT_W'(e_frame), CNT_W'(0), CNT_W'(e_errcnt), e_flags};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL back_to_back: got %h expected %h", got, exp);
    end
    checks++;
    if (InFrame !== open || Idle !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_state: got InFrame=%b Idle=%b expected %b and 0", InFrame, Idle, open);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_good_frame();
    test_flag_latency();
    test_abort(1'b0);
    test_abort(1'b1);
    test_alignment();
    test_length_clear();
    test_long_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
